// File: rtl/jellyvl_etherneco_packet_parser.sv
// jellyvl_etherneco_packet_parser: splits an EtherNeco byte stream into header fields and an indexed payload stream.
// Checks the length field against MAX_LENGTH and the trailing CRC-32 FCS.
module jellyvl_etherneco_packet_parser #(
   parameter logic [15:0] MAX_LENGTH = 16'hffff,
   parameter bit          CRC_ENABLE = 1'b1,
   parameter bit          DEBUG      = 1'b0
) (
   input  logic        rst_n_i,
   input  logic        clk_i,
   input  logic        s_rx_first_i,
   input  logic        s_rx_last_i,
   input  logic [7:0]  s_rx_data_i,
   input  logic        s_rx_valid_i,
   output logic        rx_start_o,
   output logic        rx_end_o,
   output logic        rx_error_o,
   output logic [15:0] rx_length_o,
   output logic [7:0]  rx_type_o,
   output logic [7:0]  rx_node_o,
   output logic        m_payload_first_o,
   output logic        m_payload_last_o,
   output logic [15:0] m_payload_pos_o,
   output logic [7:0]  m_payload_data_o,
   output logic        m_payload_valid_o
);
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FCS, DROP} state_t;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hedb88320 : r >> 1;
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, len_q, len_d, pos_q, pos_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  type_q, type_d, node_q, node_d, pdata_q, pdata_d;
   logic        ok_q, ok_d, pend_q, pend_d;
   logic        start_q, start_d, end_q, end_d, err_q, err_d;
   logic        pv_q, pv_d, pf_q, pf_d, pl_q, pl_d;

   logic [31:0] crc_nx, crc_out;
   logic [7:0]  fcs_byte;
   logic        too_long, at_end, fcs_match, fcs_good;

   assign crc_nx    = crc_byte(s_rx_first_i ? 32'hffffffff : crc_q, s_rx_data_i);
   assign crc_out   = ~crc_q;
   assign fcs_byte  = crc_out[{cnt_q[1:0], 3'b000} +: 8];
   assign fcs_match = s_rx_data_i == fcs_byte;
   assign fcs_good  = (ok_q && fcs_match) || !CRC_ENABLE;
   assign too_long  = cnt_q == 16'd3 && 32'({s_rx_data_i, len_q[7:0]}) > 32'(MAX_LENGTH);
   assign at_end    = cnt_q == len_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      ok_d    = ok_q;
      type_d  = type_q;
      node_d  = node_q;
      len_d   = len_q;
      start_d = 1'b0;
      end_d   = 1'b0;
      err_d   = pend_q;
      pend_d  = 1'b0;
      pv_d    = 1'b0;
      pf_d    = pf_q;
      pl_d    = pl_q;
      pos_d   = pos_q;
      pdata_d = pdata_q;
      if (s_rx_valid_i && s_rx_first_i) begin
         // a first byte aborts any frame still being parsed
         start_d = 1'b1;
         if (state_q != IDLE && state_q != DROP) err_d = 1'b1;
         type_d  = s_rx_data_i;
         crc_d   = crc_nx;
         cnt_d   = 16'd1;
         pend_d  = s_rx_last_i;
         state_d = s_rx_last_i ? IDLE : HEADER;
      end else if (s_rx_valid_i) begin
         case (state_q)
            HEADER: begin
               crc_d = crc_nx;
               cnt_d = cnt_q == 16'd3 ? 16'd0 : cnt_q + 16'd1;
               if (cnt_q == 16'd1) node_d = s_rx_data_i;
               if (cnt_q == 16'd2) len_d[7:0] = s_rx_data_i;
               if (cnt_q == 16'd3) len_d[15:8] = s_rx_data_i;
               if (too_long || s_rx_last_i) err_d = 1'b1;
               if (s_rx_last_i) state_d = IDLE;
               else if (cnt_q == 16'd3) state_d = too_long ? DROP : PAYLOAD;
            end
            PAYLOAD: begin
               pv_d    = 1'b1;
               pf_d    = cnt_q == 16'd0;
               pl_d    = at_end;
               pos_d   = cnt_q;
               pdata_d = s_rx_data_i;
               crc_d   = crc_nx;
               cnt_d   = at_end ? 16'd0 : cnt_q + 16'd1;
               ok_d    = 1'b1;
               if (s_rx_last_i) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (at_end) state_d = FCS;
            end
            FCS: begin
               ok_d  = ok_q && fcs_match;
               cnt_d = cnt_q + 16'd1;
               if (cnt_q[1:0] == 2'd3) begin
                  end_d   = s_rx_last_i && fcs_good;
                  err_d   = !(s_rx_last_i && fcs_good);
                  state_d = s_rx_last_i ? IDLE : DROP;
               end else if (s_rx_last_i) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            DROP: if (s_rx_last_i) state_d = IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         crc_q   <= '0;
         ok_q    <= 1'b0;
         type_q  <= '0;
         node_q  <= '0;
         len_q   <= '0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         pv_q    <= 1'b0;
         pf_q    <= 1'b0;
         pl_q    <= 1'b0;
         pos_q   <= '0;
         pdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         ok_q    <= ok_d;
         type_q  <= type_d;
         node_q  <= node_d;
         len_q   <= len_d;
         start_q <= start_d;
         end_q   <= end_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         pv_q    <= pv_d;
         pf_q    <= pf_d;
         pl_q    <= pl_d;
         pos_q   <= pos_d;
         pdata_q <= pdata_d;
      end
   end

   generate
      if (DEBUG) begin : g_debug
         (* mark_debug = "true" *) logic [6:0] dbg_unused_q;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) dbg_unused_q <= '0;
            else dbg_unused_q <= {state_q, start_q, end_q, err_q, pv_q};
         end
      end
   endgenerate

   assign rx_start_o        = start_q;
   assign rx_end_o          = end_q;
   assign rx_error_o        = err_q;
   assign rx_length_o       = len_q;
   assign rx_type_o         = type_q;
   assign rx_node_o         = node_q;
   assign m_payload_first_o = pf_q;
   assign m_payload_last_o  = pl_q;
   assign m_payload_pos_o   = pos_q;
   assign m_payload_data_o  = pdata_q;
   assign m_payload_valid_o = pv_q;
endmodule

// File: tb/tb_jellyvl_etherneco_packet_parser.sv
// tb_jellyvl_etherneco_packet_parser: two parser instances (default, and MAX_LENGTH=0x10 with CRC off)
// fed the same stream; a frame-level reference model fills per-instance expectation queues.
module tb_jellyvl_etherneco_packet_parser;
   logic clk = 1'b0, rst_n = 1'b0;
   logic s_first = 1'b0, s_last = 1'b0, s_valid = 1'b0;
   logic [7:0] s_data = 8'd0;
   always #5 clk = ~clk;

   logic        a_st, a_fin, a_er, a_pf, a_pl, a_pv, b_st, b_fin, b_er, b_pf, b_pl, b_pv;
   logic [15:0] a_len, a_pos, b_len, b_pos;
   logic [7:0]  a_typ, a_nod, a_dat, b_typ, b_nod, b_dat;

   jellyvl_etherneco_packet_parser dut_a (
      .rst_n_i(rst_n), .clk_i(clk), .s_rx_first_i(s_first), .s_rx_last_i(s_last),
      .s_rx_data_i(s_data), .s_rx_valid_i(s_valid), .rx_start_o(a_st), .rx_end_o(a_fin),
      .rx_error_o(a_er), .rx_length_o(a_len), .rx_type_o(a_typ), .rx_node_o(a_nod),
      .m_payload_first_o(a_pf), .m_payload_last_o(a_pl), .m_payload_pos_o(a_pos),
      .m_payload_data_o(a_dat), .m_payload_valid_o(a_pv));

   jellyvl_etherneco_packet_parser #(.MAX_LENGTH(16'h0010), .CRC_ENABLE(1'b0)) dut_b (
      .rst_n_i(rst_n), .clk_i(clk), .s_rx_first_i(s_first), .s_rx_last_i(s_last),
      .s_rx_data_i(s_data), .s_rx_valid_i(s_valid), .rx_start_o(b_st), .rx_end_o(b_fin),
      .rx_error_o(b_er), .rx_length_o(b_len), .rx_type_o(b_typ), .rx_node_o(b_nod),
      .m_payload_first_o(b_pf), .m_payload_last_o(b_pl), .m_payload_pos_o(b_pos),
      .m_payload_data_o(b_dat), .m_payload_valid_o(b_pv));

   typedef struct {
      int cyc;
      bit st, fin, er, bv, bf, bl;
      logic [15:0] pos, len;
      logic [7:0] dat, typ, nod;
   } ev_t;

   ev_t qa[$], qb[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit act[2];
   logic [7:0] fb[2][0:63];
   int fn[2];
   logic [15:0] maxl[2] = '{16'hffff, 16'h0010};
   bit crce[2] = '{1'b1, 1'b0};
   logic [7:0] fr[0:63];
   int ftx;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_crc(input int u, input int n);
      logic [31:0] c = 32'hffffffff;
      for (int i = 0; i < n; i++) begin
         c ^= {24'd0, fb[u][i]};
         for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
      end
      return ~c;
   endfunction

   function automatic ev_t blank(input int k);
      ev_t e = '{default: 0};
      e.cyc = k;
      return e;
   endfunction

   function automatic ev_t merge(input ev_t a, input ev_t b);
      ev_t r = a;
      r.st |= b.st; r.fin |= b.fin; r.er |= b.er;
      if (b.bv || b.fin) begin
         r.bv = b.bv; r.bf = b.bf; r.bl = b.bl; r.pos = b.pos;
         r.dat = b.dat; r.typ = b.typ; r.nod = b.nod; r.len = b.len;
      end
      return r;
   endfunction

   task automatic add(input int u, input ev_t e);
      if (u == 0) begin
         if (qa.size() > 0 && qa[qa.size()-1].cyc == e.cyc) qa[qa.size()-1] = merge(qa[qa.size()-1], e);
         else qa.push_back(e);
      end else begin
         if (qb.size() > 0 && qb[qb.size()-1].cyc == e.cyc) qb[qb.size()-1] = merge(qb[qb.size()-1], e);
         else qb.push_back(e);
      end
   endtask

   // Reference: classify each accepted byte by its index within the current frame.
   task automatic model(input int u, input logic [7:0] d, input bit f, input bit l, input int k);
      ev_t e = blank(k);
      int i;
      logic [15:0] L;
      logic [31:0] fcs;
      if (f) begin
         e.er = act[u];
         e.st = 1'b1;
         fb[u][0] = d; fn[u] = 1; act[u] = 1'b1;
         add(u, e);
         if (l) begin
            e = blank(k + 1); e.er = 1'b1; act[u] = 1'b0;
            add(u, e);
         end
         return;
      end
      if (!act[u]) return;
      i = fn[u];
      fb[u][i] = d; fn[u]++;
      L = {fb[u][3], fb[u][2]};
      if (i <= 3) begin
         if ((i == 3 && L > maxl[u]) || l) begin
            e.er = 1'b1; act[u] = 1'b0; add(u, e);
         end
      end else if (i <= 4 + int'(L)) begin
         e.bv = 1'b1; e.pos = 16'(i - 4); e.bf = i == 4; e.bl = i == 4 + int'(L);
         e.dat = d; e.typ = fb[u][0]; e.nod = fb[u][1]; e.len = L;
         if (l) begin e.er = 1'b1; act[u] = 1'b0; end
         add(u, e);
      end else if (i == 8 + int'(L)) begin
         fcs = {fb[u][8+L], fb[u][7+L], fb[u][6+L], fb[u][5+L]};
         act[u] = 1'b0;
         if (l && (!crce[u] || fcs == ref_crc(u, 5 + int'(L)))) begin
            e.fin = 1'b1; e.typ = fb[u][0]; e.nod = fb[u][1]; e.len = L;
         end else e.er = 1'b1;
         add(u, e);
      end else if (l) begin
         e.er = 1'b1; act[u] = 1'b0; add(u, e);
      end
   endtask

   task automatic chk(input int u, input bit st, fin, er, bv, bf, bl,
                      input logic [15:0] pos, len, input logic [7:0] dat, typ, nod);
      ev_t e;
      bit have, bad;
      have = u == 0 ? qa.size() > 0 : qb.size() > 0;
      if (have) e = u == 0 ? qa[0] : qb[0];
      while (have && e.cyc < cyc) begin
         n_cmp++; n_bad++;
         $display("FAIL dut%0d missing event: expected at cycle %0d st=%0d end=%0d err=%0d beat=%0d, got nothing",
                  u, e.cyc, e.st, e.fin, e.er, e.bv);
         if (u == 0) void'(qa.pop_front()); else void'(qb.pop_front());
         have = u == 0 ? qa.size() > 0 : qb.size() > 0;
         if (have) e = u == 0 ? qa[0] : qb[0];
      end
      if (!(st || fin || er || bv || (have && e.cyc == cyc))) return;
      if (have && e.cyc == cyc) begin
         if (u == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end else e = blank(cyc);
      n_cmp++;
      bad = {st, fin, er, bv} != {e.st, e.fin, e.er, e.bv};
      if (bv && {bf, bl, pos, dat, typ, nod, len} != {e.bf, e.bl, e.pos, e.dat, e.typ, e.nod, e.len}) bad = 1'b1;
      if (fin && {typ, nod, len} != {e.typ, e.nod, e.len}) bad = 1'b1;
      if (bad) begin
         n_bad++;
         $display("FAIL dut%0d cycle %0d: got st=%0d end=%0d err=%0d v=%0d f=%0d l=%0d pos=%h d=%h t=%h n=%h len=%h, want st=%0d end=%0d err=%0d v=%0d f=%0d l=%0d pos=%h d=%h t=%h n=%h len=%h",
                  u, cyc, st, fin, er, bv, bf, bl, pos, dat, typ, nod, len,
                  e.st, e.fin, e.er, e.bv, e.bf, e.bl, e.pos, e.dat, e.typ, e.nod, e.len);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk(0, a_st, a_fin, a_er, a_pv, a_pf, a_pl, a_pos, a_len, a_dat, a_typ, a_nod);
         chk(1, b_st, b_fin, b_er, b_pv, b_pf, b_pl, b_pos, b_len, b_dat, b_typ, b_nod);
      end
   end

   task automatic build(input logic [7:0] t, n, input logic [15:0] len, input bit rnd, input bit corrupt);
      logic [31:0] c = 32'hffffffff;
      fr[0] = t; fr[1] = n; fr[2] = len[7:0]; fr[3] = len[15:8];
      for (int i = 0; i <= int'(len); i++) fr[4+i] = rnd ? 8'($urandom) : 8'(i);
      ftx = 9 + int'(len);
      for (int i = 0; i < ftx - 4; i++) begin
         c ^= {24'd0, fr[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
      end
      c = ~c;
      for (int i = 0; i < 4; i++) fr[ftx-4+i] = c[8*i +: 8];
      if (corrupt) fr[ftx-4] ^= 8'h01;
   endtask

   task automatic send(input int n, input int last_idx, input int gapmax);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
         s_valid = 1'b1; s_first = i == 0; s_last = i == last_idx; s_data = fr[i];
         model(0, s_data, s_first, s_last, cyc + 1);
         model(1, s_data, s_first, s_last, cyc + 1);
         @(posedge clk); #1;
         s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      end
   endtask

   task automatic check_zero(input string name);
      n_cmp++;
      if ({a_st, a_fin, a_er, a_pv, a_pos, a_len, a_typ, a_nod, b_st, b_fin, b_er, b_pv, b_pos, b_len} != '0) begin
         n_bad++;
         $display("FAIL %s: outputs a={%0d%0d%0d%0d pos=%h len=%h t=%h n=%h} b={%0d%0d%0d%0d pos=%h len=%h}, want all 0",
                  name, a_st, a_fin, a_er, a_pv, a_pos, a_len, a_typ, a_nod, b_st, b_fin, b_er, b_pv, b_pos, b_len);
      end
   endtask

   initial begin
      int len, kind, n;
      #2 check_zero("reset_state");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      build(8'h10, 8'h01, 16'd8, 1'b0, 1'b0); send(ftx, ftx - 1, 0);
      build(8'h10, 8'h01, 16'd8, 1'b0, 1'b1); send(ftx, ftx - 1, 0);
      build(8'h10, 8'h01, 16'd8, 1'b0, 1'b0); send(10, 9, 0);
      send(ftx, ftx - 1, 0);
      send(8, -1, 0);
      build(8'h22, 8'h33, 16'd4, 1'b1, 1'b0); send(ftx, ftx - 1, 0);
      build(8'h05, 8'h06, 16'd0, 1'b1, 1'b0); send(ftx, ftx - 1, 0);
      build(8'h07, 8'h08, 16'h0011, 1'b1, 1'b0); send(ftx, ftx - 1, 0);
      fr[0] = 8'h55; send(1, 0, 0);
      build(8'h0a, 8'h0b, 16'd3, 1'b1, 1'b0);
      fr[ftx] = 8'haa; fr[ftx+1] = 8'hbb; send(ftx + 2, ftx + 1, 0);
      send(3, 2, 0);
      repeat (3) @(posedge clk); #1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(20, 0);
         kind = $urandom_range(9, 0);
         build(8'($urandom), 8'($urandom), 16'(len), 1'b1, $urandom_range(3, 0) == 0);
         n = kind < 2 ? $urandom_range(ftx, 1) : ftx;
         send(n, kind == 1 ? -1 : n - 1, 2);
      end
      build(8'h31, 8'h32, 16'd10, 1'b1, 1'b0); send(9, -1, 2);
      rst_n = 1'b0;
      #1 check_zero("async_reset");
      qa.delete(); qb.delete(); act[0] = 1'b0; act[1] = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      build(8'h41, 8'h42, 16'd6, 1'b1, 1'b0); send(ftx, ftx - 1, 2);
      repeat (5) @(posedge clk);
      #1;
      if (qa.size() + qb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expected events never seen, want 0", qa.size() + qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
